// File: rtl/vram_responder_pkg.sv
// vram_responder_pkg
// Shared definitions for the PPU VRAM bus blocks: level-shifter direction
// codes, the responder FSM state encoding and the layout of the
// synchronized bus bundle.
package vram_responder_pkg;

   localparam logic LVL_DIR_INPUT  = 1'b0;
   localparam logic LVL_DIR_OUTPUT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_WAIT  = 2'd1,
      ST_RD_DRIVE = 2'd2,
      ST_RD_ABORT = 2'd3
   } rsp_state_e;

   // Strobes sit in the low bits so the synchronizer can edge-detect them
   // with a small EDGE_W.
   typedef struct packed {
      logic [7:0]  vdb;
      logic [7:0]  vda;
      logic [13:0] vab;
      logic [13:0] vaa;
      logic        va14;
      logic        vbwr_n;
      logic        vawr_n;
      logic        vrd_n;
   } bus_t;

   localparam int BUS_W = $bits(bus_t);

   // Strobes idle high out of reset so no false edge follows reset release.
   localparam logic [BUS_W-1:0] BUS_RST = {45'd0, 3'b111};

endpackage

// File: rtl/vram_responder_sync.sv
// vram_sync
// STAGES-deep synchronizer for a WIDTH-bit bundle. All bits share one
// pipeline so they stay aligned. The low EDGE_W bits also get falling and
// rising edge pulses, valid in the same cycle as the new dout level.
// Ports: clk, rst_n (async active-low), din (async bundle),
//        dout (synchronized bundle), fall/rise (edge pulses, low EDGE_W bits).
module vram_sync #(
   parameter int               WIDTH   = 1,
   parameter int               STAGES  = 2,
   parameter int               EDGE_W  = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [EDGE_W-1:0] fall,
   output logic [EDGE_W-1:0] rise
);

   logic [WIDTH-1:0]  stage_r [STAGES];
   logic [EDGE_W-1:0] edge_d_r;

   // Synchronizer chain plus one-cycle history of the edge-detected bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= RST_VAL;
         end
         edge_d_r <= RST_VAL[EDGE_W-1:0];
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
         edge_d_r <= stage_r[STAGES-1][EDGE_W-1:0];
      end
   end

   assign dout = stage_r[STAGES-1];
   assign fall = edge_d_r & ~dout[EDGE_W-1:0];
   assign rise = ~edge_d_r & dout[EDGE_W-1:0];

endmodule

// File: rtl/vram_responder.sv
// vram_responder
// Responding end of the PPU VRAM bus, emulating chip A (low byte) and chip B
// (high byte). Reads go to a client over rd_req/rd_ack and the returned
// bytes are driven on vda/vdb; writes become one-cycle wr_valid events.
// Ports: clk, rst_n; PPU bus vrd_n, vawr_n, vbwr_n, va14, vaa, vab, vda, vdb;
//        level-shifter lvl_va_dir, lvl_vd_dir; read client rd_req, rd_addr_a,
//        rd_addr_b, rd_ack, rd_data_a, rd_data_b; write client wr_valid,
//        wr_sel_b, wr_addr, wr_data; sticky rd_late, bus_err.
// Optional: define VRAM_RESPONDER_STATS_EN to add rd_count / wr_count.
module vram_responder
   import vram_responder_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vrd_n,
   input  logic        vawr_n,
   input  logic        vbwr_n,
   input  logic        va14,
   input  logic [13:0] vaa,
   input  logic [13:0] vab,
   output logic        lvl_va_dir,
   output logic        lvl_vd_dir,
   inout  wire  [7:0]  vda,
   inout  wire  [7:0]  vdb,
   output logic        rd_req,
   output logic [14:0] rd_addr_a,
   output logic [14:0] rd_addr_b,
   input  logic        rd_ack,
   input  logic [7:0]  rd_data_a,
   input  logic [7:0]  rd_data_b,
   output logic        wr_valid,
   output logic        wr_sel_b,
   output logic [14:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_late,
   output logic        bus_err
`ifdef VRAM_RESPONDER_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   bus_t        bus_in_s, bus_s;
   logic [2:0]  fall_s, rise_s;
   logic        unused_wr_fall_s;
   rsp_state_e  state_r, state_nx;
   logic        rd_start_s, rd_take_s, rd_drop_s, late_s, conflict_s, wr_ok_s;
   logic        rd_req_r, drive_r, lvl_vd_dir_r, rd_late_r, bus_err_r;
   logic [14:0] rd_addr_a_r, rd_addr_b_r;
   logic [7:0]  drv_a_r, drv_b_r;
   logic [14:0] cap_a_addr_r, cap_b_addr_r, pend_addr_r, wr_addr_r;
   logic [7:0]  cap_a_data_r, cap_b_data_r, pend_data_r, wr_data_r;
   logic        pend_b_r, wr_valid_r, wr_sel_b_r;

   assign bus_in_s = {vdb, vda, vab, vaa, va14, vbwr_n, vawr_n, vrd_n};

   vram_sync #(
      .WIDTH   (BUS_W),
      .STAGES  (SYNC_STAGES),
      .EDGE_W  (3),
      .RST_VAL (BUS_RST)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (bus_in_s),
      .dout (bus_s),
      .fall (fall_s),
      .rise (rise_s)
   );

   // Write-strobe falls carry no meaning here; only their rises do.
   assign unused_wr_fall_s = ^fall_s[2:1];

   assign conflict_s = ~bus_s.vrd_n & (~bus_s.vawr_n | ~bus_s.vbwr_n);
   assign wr_ok_s    = (state_r != ST_RD_DRIVE);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // FSM next state and per-cycle read-path strobes.
   always_comb begin
      state_nx   = state_r;
      rd_start_s = 1'b0;
      rd_take_s  = 1'b0;
      rd_drop_s  = 1'b0;
      late_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s[0] && bus_s.vawr_n && bus_s.vbwr_n) begin
               rd_start_s = 1'b1;
               state_nx   = ST_RD_WAIT;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            // Strobe gone (or collided with a write): the read is abandoned.
            // An ack arriving in that same cycle is consumed and discarded.
            if (bus_s.vrd_n || conflict_s) begin
               late_s = bus_s.vrd_n;
               if (rd_ack) begin
                  rd_drop_s = 1'b1;
                  state_nx  = ST_IDLE;
               end else begin
                  state_nx = ST_RD_ABORT;
               end
            end else if (rd_ack) begin
               rd_take_s = 1'b1;
               rd_drop_s = 1'b1;
               state_nx  = ST_RD_DRIVE;
            end else begin
               state_nx = ST_RD_WAIT;
            end
         end
         ST_RD_DRIVE: begin
            if (rise_s[0] || conflict_s) begin
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_RD_DRIVE;
            end
         end
         ST_RD_ABORT: begin
            if (rd_ack) begin
               rd_drop_s = 1'b1;
               state_nx  = ST_IDLE;
            end else begin
               state_nx = ST_RD_ABORT;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Read request, latched addresses/data, bus drive enable, sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_req_r     <= 1'b0;
         rd_addr_a_r  <= 15'd0;
         rd_addr_b_r  <= 15'd0;
         drv_a_r      <= 8'd0;
         drv_b_r      <= 8'd0;
         drive_r      <= 1'b0;
         lvl_vd_dir_r <= LVL_DIR_INPUT;
         rd_late_r    <= 1'b0;
         bus_err_r    <= 1'b0;
      end else begin
         if (rd_start_s) begin
            rd_req_r    <= 1'b1;
            rd_addr_a_r <= {bus_s.va14, bus_s.vaa};
            rd_addr_b_r <= {bus_s.va14, bus_s.vab};
         end else if (rd_drop_s) begin
            rd_req_r <= 1'b0;
         end
         if (rd_take_s) begin
            drv_a_r <= rd_data_a;
            drv_b_r <= rd_data_b;
         end
         drive_r      <= (state_nx == ST_RD_DRIVE);
         lvl_vd_dir_r <= (state_nx == ST_RD_DRIVE) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
         rd_late_r    <= rd_late_r | late_s;
         bus_err_r    <= bus_err_r | conflict_s;
      end
   end

   // Address/data seen during the most recent synchronized-low write cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_a_addr_r <= 15'd0;
         cap_a_data_r <= 8'd0;
         cap_b_addr_r <= 15'd0;
         cap_b_data_r <= 8'd0;
      end else begin
         if (!bus_s.vawr_n) begin
            cap_a_addr_r <= {bus_s.va14, bus_s.vaa};
            cap_a_data_r <= bus_s.vda;
         end
         if (!bus_s.vbwr_n) begin
            cap_b_addr_r <= {bus_s.va14, bus_s.vab};
            cap_b_data_r <= bus_s.vdb;
         end
      end
   end

   // Write events; a B rise coinciding with an A rise waits one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid_r  <= 1'b0;
         wr_sel_b_r  <= 1'b0;
         wr_addr_r   <= 15'd0;
         wr_data_r   <= 8'd0;
         pend_b_r    <= 1'b0;
         pend_addr_r <= 15'd0;
         pend_data_r <= 8'd0;
      end else if (pend_b_r) begin
         wr_valid_r <= 1'b1;
         wr_sel_b_r <= 1'b1;
         wr_addr_r  <= pend_addr_r;
         wr_data_r  <= pend_data_r;
         pend_b_r   <= 1'b0;
      end else if (wr_ok_s && rise_s[1]) begin
         wr_valid_r  <= 1'b1;
         wr_sel_b_r  <= 1'b0;
         wr_addr_r   <= cap_a_addr_r;
         wr_data_r   <= cap_a_data_r;
         pend_b_r    <= rise_s[2];
         pend_addr_r <= cap_b_addr_r;
         pend_data_r <= cap_b_data_r;
      end else if (wr_ok_s && rise_s[2]) begin
         wr_valid_r <= 1'b1;
         wr_sel_b_r <= 1'b1;
         wr_addr_r  <= cap_b_addr_r;
         wr_data_r  <= cap_b_data_r;
      end else begin
         wr_valid_r <= 1'b0;
      end
   end

`ifdef VRAM_RESPONDER_STATS_EN
   logic [15:0] rd_count_r, wr_count_r;

   // Free-running transaction counters, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_r <= 16'd0;
         wr_count_r <= 16'd0;
      end else begin
         if (rd_start_s) begin
            rd_count_r <= rd_count_r + 16'd1;
         end
         if (wr_valid_r) begin
            wr_count_r <= wr_count_r + 16'd1;
         end
      end
   end

   assign rd_count = rd_count_r;
   assign wr_count = wr_count_r;
`endif

   assign lvl_va_dir = LVL_DIR_INPUT;
   assign lvl_vd_dir = lvl_vd_dir_r;
   assign vda        = drive_r ? drv_a_r : 8'hzz;
   assign vdb        = drive_r ? drv_b_r : 8'hzz;
   assign rd_req     = rd_req_r;
   assign rd_addr_a  = rd_addr_a_r;
   assign rd_addr_b  = rd_addr_b_r;
   assign wr_valid   = wr_valid_r;
   assign wr_sel_b   = wr_sel_b_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign rd_late    = rd_late_r;
   assign bus_err    = bus_err_r;

endmodule

// File: tb/tb_vram_responder.sv
module tb_vram_responder;
   import vram_responder_pkg::*;

   localparam int LAT = 3;   // SYNC_STAGES + 1 with the default depth

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vrd_n, vawr_n, vbwr_n, va14;
   logic [13:0] vaa, vab;
   wire  [7:0]  vda, vdb;
   logic [7:0]  tb_da, tb_db;
   logic        tb_drv;
   logic        lvl_va_dir, lvl_vd_dir;
   logic        rd_req, rd_ack;
   logic [14:0] rd_addr_a, rd_addr_b, wr_addr;
   logic [7:0]  rd_data_a, rd_data_b, wr_data;
   logic        wr_valid, wr_sel_b, rd_late, bus_err;
`ifdef VRAM_RESPONDER_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif

   assign vda = tb_drv ? tb_da : 8'hzz;
   assign vdb = tb_drv ? tb_db : 8'hzz;

   vram_responder dut (
      .clk(clk), .rst_n(rst_n), .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n),
      .va14(va14), .vaa(vaa), .vab(vab), .lvl_va_dir(lvl_va_dir),
      .lvl_vd_dir(lvl_vd_dir), .vda(vda), .vdb(vdb), .rd_req(rd_req),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ack(rd_ack),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_valid(wr_valid),
      .wr_sel_b(wr_sel_b), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_late(rd_late), .bus_err(bus_err)
`ifdef VRAM_RESPONDER_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic [14:0] addr;
      logic [7:0]  data;
      int          cyc;
   } ev_t;

   typedef struct {
      logic        is_rd;
      logic        wa, wb, v14;
      logic [13:0] aa, ab;
      logic [7:0]  da, db;
      int          dly;
      logic [14:0] ea, eb;   // read: rd_addr_a/b; write: A/B event address
   } vec_t;

   int  checks = 0, failures = 0;
   int  cyc = 0, drive_seen = 0, req_seen = 0;
   ev_t ev_q[$];
   ev_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: collects write events and counts drive/request cycles.
   always @(negedge clk) begin
      if (wr_valid === 1'b1) ev_q.push_back('{wr_sel_b, wr_addr, wr_data, cyc});
      if (lvl_vd_dir === LVL_DIR_OUTPUT) drive_seen <= drive_seen + 1;
      if (rd_req === 1'b1) req_seen <= req_seen + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic ncyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_events(input string tag);
      chk({tag, ".count"}, ev_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
         chk($sformatf("%s.sel%0d", tag, i),  ev_q[i].sel,  exp_q[i].sel);
         chk($sformatf("%s.addr%0d", tag, i), ev_q[i].addr, exp_q[i].addr);
         chk($sformatf("%s.data%0d", tag, i), ev_q[i].data, exp_q[i].data);
         chk($sformatf("%s.cyc%0d", tag, i),  ev_q[i].cyc,  exp_q[i].cyc);
      end
      ev_q.delete();
   endtask

   // Pulses the requested write strobes; returns the cycle of the pin rise.
   task automatic apply_write(input logic a, b, v14, input logic [13:0] aa, ab,
                              input logic [7:0] da, db, output int rc);
      @(negedge clk);
      va14 = v14; vaa = aa; vab = ab; tb_da = da; tb_db = db; tb_drv = 1'b1;
      vawr_n = ~a; vbwr_n = ~b;
      ncyc(3);
      vawr_n = 1'b1; vbwr_n = 1'b1; rc = cyc;
      // Values after the rise must not be captured.
      vaa = ~aa; vab = ~ab; tb_da = ~da; tb_db = ~db; va14 = ~v14;
      ncyc(LAT + 3);
      tb_drv = 1'b0;
   endtask

   // Reference model: chip A event first, then chip B on the following cycle.
   task automatic model_write(input logic a, b, input logic [14:0] addr_a, addr_b,
                              input logic [7:0] da, db, input int rc);
      exp_q.delete();
      if (a) exp_q.push_back('{1'b0, addr_a, da, rc + LAT});
      if (b) exp_q.push_back('{1'b1, addr_b, db, rc + LAT + (a ? 1 : 0)});
   endtask

   task automatic apply_read(input string tag, input logic v14, input logic [13:0] aa, ab,
                             input logic [7:0] da, db, input int dly,
                             input logic [14:0] ea, eb);
      int t0;
      @(negedge clk);
      va14 = v14; vaa = aa; vab = ab; tb_drv = 1'b0; vrd_n = 1'b0; t0 = cyc;
      for (int i = 0; i < 12; i++) begin
         if (rd_req === 1'b1) break;
         @(negedge clk);
      end
      chk({tag, ".req_lat"}, cyc - t0, LAT);
      chk({tag, ".addr_a"}, rd_addr_a, ea);
      chk({tag, ".addr_b"}, rd_addr_b, eb);
      ncyc(dly);
      rd_ack = 1'b1; rd_data_a = da; rd_data_b = db;
      @(negedge clk);
      rd_ack = 1'b0; rd_data_a = ~da; rd_data_b = ~db;
      chk({tag, ".req_drop"}, rd_req, 1'b0);
      chk({tag, ".dir_out"}, lvl_vd_dir, LVL_DIR_OUTPUT);
      chk({tag, ".vda"}, vda, da);
      chk({tag, ".vdb"}, vdb, db);
      ncyc(1);
      vrd_n = 1'b1; t0 = cyc;
      for (int i = 0; i < 12; i++) begin
         if (lvl_vd_dir === LVL_DIR_INPUT) break;
         @(negedge clk);
      end
      chk({tag, ".rel_lat"}, cyc - t0, LAT);
      chk({tag, ".vda_rel"}, (vda !== da), 1'b1);
      chk({tag, ".vdb_rel"}, (vdb !== db), 1'b1);
      ncyc(2);
   endtask

   vec_t vecs[6];

   initial begin
      int rc, d0, r0;
      logic        a, b, v14;
      logic [13:0] aa, ab;
      logic [7:0]  da, db;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 14'h0123, 14'h0456, 8'hA5, 8'h5A, 2, 15'h4123, 15'h4456};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h1FFF, 14'h0000, 8'h3C, 8'h00, 0, 15'h1FFF, 15'h0000};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 14'h0000, 14'h0000, 8'h00, 8'hC3, 0, 15'h4000, 15'h4000};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 14'h2AAA, 14'h1555, 8'h11, 8'h22, 0, 15'h6AAA, 15'h5555};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 14'h3FFF, 14'h0000, 8'h01, 8'hFF, 0, 15'h3FFF, 15'h0000};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 14'h3FFF, 8'h00, 8'h80, 0, 15'h3FFF, 15'h3FFF};

      rst_n = 1'b0; vrd_n = 1'b1; vawr_n = 1'b1; vbwr_n = 1'b1; va14 = 1'b0;
      vaa = 14'd0; vab = 14'd0; tb_da = 8'd0; tb_db = 8'd0; tb_drv = 1'b0;
      rd_ack = 1'b0; rd_data_a = 8'd0; rd_data_b = 8'd0;
      ncyc(2);
      chk("rst.rd_req", rd_req, 1'b0);
      chk("rst.wr_valid", wr_valid, 1'b0);
      chk("rst.rd_late", rd_late, 1'b0);
      chk("rst.bus_err", bus_err, 1'b0);
      chk("rst.rd_addr_a", rd_addr_a, 15'd0);
      chk("rst.rd_addr_b", rd_addr_b, 15'd0);
      chk("rst.wr_addr", wr_addr, 15'd0);
      chk("rst.wr_data", wr_data, 8'd0);
      chk("rst.wr_sel_b", wr_sel_b, 1'b0);
      chk("rst.vd_dir", lvl_vd_dir, LVL_DIR_INPUT);
      chk("rst.va_dir", lvl_va_dir, LVL_DIR_INPUT);
`ifdef VRAM_RESPONDER_STATS_EN
      chk("rst.rd_count", rd_count, 16'd0);
      chk("rst.wr_count", wr_count, 16'd0);
`endif
      rst_n = 1'b1;
      ncyc(4);
      ev_q.delete();

      // Directed vectors.
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].is_rd) begin
            apply_read($sformatf("vec%0d", i), vecs[i].v14, vecs[i].aa, vecs[i].ab,
                       vecs[i].da, vecs[i].db, vecs[i].dly, vecs[i].ea, vecs[i].eb);
         end else begin
            apply_write(vecs[i].wa, vecs[i].wb, vecs[i].v14, vecs[i].aa, vecs[i].ab,
                        vecs[i].da, vecs[i].db, rc);
            model_write(vecs[i].wa, vecs[i].wb, vecs[i].ea, vecs[i].eb,
                        vecs[i].da, vecs[i].db, rc);
            check_events($sformatf("vec%0d", i));
         end
      end

      // Randomized transactions against the reference model.
      for (int n = 0; n < 24; n++) begin
         int op;
         op  = $urandom_range(0, 3);
         v14 = 1'($urandom_range(0, 1));
         aa  = 14'($urandom);
         ab  = 14'($urandom);
         da  = 8'($urandom_range(1, 255));
         db  = 8'($urandom_range(1, 255));
         if (op == 0) begin
            apply_read($sformatf("rnd%0d", n), v14, aa, ab, da, db,
                       $urandom_range(0, 4), {v14, aa}, {v14, ab});
         end else begin
            a = (op != 2);
            b = (op != 1);
            apply_write(a, b, v14, aa, ab, da, db, rc);
            model_write(a, b, {v14, aa}, {v14, ab}, da, db, rc);
            check_events($sformatf("rnd%0d", n));
         end
      end

      // Late ack: strobe ends before the client answers.
      chk("late.pre", rd_late, 1'b0);
      d0 = drive_seen;
      @(negedge clk);
      va14 = 1'b0; vaa = 14'h0011; vab = 14'h0022; vrd_n = 1'b0;
      ncyc(3);
      vrd_n = 1'b1;
      ncyc(10);
      chk("late.flag", rd_late, 1'b1);
      chk("late.req_held", rd_req, 1'b1);
      rd_ack = 1'b1; rd_data_a = 8'h99; rd_data_b = 8'h66;
      @(negedge clk);
      rd_ack = 1'b0;
      chk("late.req_drop", rd_req, 1'b0);
      ncyc(4);
      chk("late.no_drive", drive_seen - d0, 0);
      chk("late.req_stays_low", rd_req, 1'b0);

      // Read and write strobe low together.
      chk("err.pre", bus_err, 1'b0);
      d0 = drive_seen; r0 = req_seen;
      @(negedge clk);
      va14 = 1'b0; vaa = 14'h0AAA; vab = 14'h0BBB; tb_da = 8'h77; tb_db = 8'h88;
      tb_drv = 1'b1; vrd_n = 1'b0; vawr_n = 1'b0;
      ncyc(4);
      chk("err.flag", bus_err, 1'b1);
      vrd_n = 1'b1; vawr_n = 1'b1; rc = cyc;
      ncyc(LAT + 3);
      tb_drv = 1'b0;
      chk("err.no_req", req_seen - r0, 0);
      chk("err.no_drive", drive_seen - d0, 0);
      model_write(1'b1, 1'b0, 15'h0AAA, 15'h0000, 8'h77, 8'h00, rc);
      check_events("err.wr");

      // Asynchronous reset while the bus is being driven.
      @(negedge clk);
      va14 = 1'b1; vaa = 14'h0001; vab = 14'h0002; vrd_n = 1'b0;
      ncyc(LAT + 1);
      rd_ack = 1'b1; rd_data_a = 8'hE7; rd_data_b = 8'h7E;
      @(negedge clk);
      rd_ack = 1'b0;
      chk("arst.driving", vda, 8'hE7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.dir", lvl_vd_dir, LVL_DIR_INPUT);
      chk("arst.vda_rel", (vda !== 8'hE7), 1'b1);
      chk("arst.vdb_rel", (vdb !== 8'h7E), 1'b1);
      chk("arst.rd_addr_a", rd_addr_a, 15'd0);
      chk("arst.rd_late", rd_late, 1'b0);
      chk("arst.bus_err", bus_err, 1'b0);
`ifdef VRAM_RESPONDER_STATS_EN
      chk("arst.rd_count", rd_count, 16'd0);
      chk("arst.wr_count", wr_count, 16'd0);
`endif
      @(negedge clk);
      vrd_n = 1'b1;
      rst_n = 1'b1;
      ncyc(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vram_responder.md
# vram_responder

Emulates the two 8-bit VRAM chips (A = low byte, B = high byte) on the PPU VRAM bus, the responding end of the bus that the idle-initiator stub parks in input mode. Bus strobes are synchronized into `clk`. Reads are forwarded to an internal client over a req/ack handshake, and the returned bytes are driven onto `vda`/`vdb`. Writes are captured and emitted as single-cycle write events to the same client.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for strobes, address and data. Legal values are 2 or 3.

Ports (clock and reset first; the clock is `clk` and the reset is `rst_n`, asynchronous and active-low):
- `clk` input 1: system clock, ≥ 8× PPU strobe rate.
- `rst_n` input 1: asynchronous active-low reset.
- `vrd_n` input 1: PPU read strobe, common to A and B.
- `vawr_n` input 1: write strobe, chip A.
- `vbwr_n` input 1: write strobe, chip B.
- `va14` input 1: address bit 14, common.
- `vaa` input 14: chip A address [13:0].
- `vab` input 14: chip B address [13:0].
- `lvl_va_dir` output 1: level-shifter direction for the address bus. Constant `LVL_DIR_INPUT`.
- `lvl_vd_dir` output 1: level-shifter direction for the data bus.
- `vda` inout 8: chip A data.
- `vdb` inout 8: chip B data.
- `rd_req` output 1: read request; held high until `rd_ack`.
- `rd_addr_a` output 15: `{va14,vaa}` latched at read start.
- `rd_addr_b` output 15: `{va14,vab}` latched at read start.
- `rd_ack` input 1: client supplies data this cycle.
- `rd_data_a` input 8: read data for A, sampled when `rd_ack`=1.
- `rd_data_b` input 8: read data for B, sampled when `rd_ack`=1.
- `wr_valid` output 1: one-cycle write event.
- `wr_sel_b` output 1: 0 = chip A, 1 = chip B.
- `wr_addr` output 15: write address.
- `wr_data` output 8: write data.
- `rd_late` output 1: sticky; the read strobe ended before `rd_ack` arrived.
- `bus_err` output 1: sticky; a read and a write strobe were low simultaneously.

## Operation
- All bus inputs pass through the same `SYNC_STAGES` pipeline, so strobe, address and data stay aligned. Edges are detected on the synchronized strobes.
- FSM states:
  - IDLE. On a `vrd_n` fall with both write strobes high: latch addresses, set `rd_req`=1, go to RD_WAIT.
  - RD_WAIT.
    - `rd_ack`=1 with `vrd_n` still low: register the data, drop `rd_req`, go to RD_DRIVE.
    - `vrd_n` rises before ack: set `rd_late`, go to RD_ABORT.
    - `rd_ack` and the `vrd_n` rise in the same cycle count as late.
  - RD_DRIVE. `lvl_vd_dir`=`LVL_DIR_OUTPUT`; `vda`/`vdb` drive the registered data. On the synchronized `vrd_n` rise, tristate and set `LVL_DIR_INPUT` in the same cycle, then go to IDLE.
  - RD_ABORT. Keep `rd_req` high until `rd_ack`, discard the data, go to IDLE.
- Writes are processed in any state except RD_DRIVE.
  - On a synchronized `vawr_n`/`vbwr_n` rise, emit `wr_valid` for one cycle with the address and data from the last synchronized-low cycle.
  - If A and B rise in the same cycle, emit A first and B on the next cycle; B is held in a one-entry buffer.
- `vda`/`vdb` are driven only in RD_DRIVE; every other state leaves them Z.
- If a read strobe and a write strobe are low together: set `bus_err`, ignore the read (no request, no drive), and still process the write.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - `lvl_vd_dir`=`LVL_DIR_INPUT`; `vda`/`vdb`=Z.
  - `rd_req`=0, `wr_valid`=0, `rd_late`=0, `bus_err`=0.
  - `rd_addr_a`, `rd_addr_b`, `wr_addr` = 0; `wr_data` = 0; `wr_sel_b`=0.
  - FSM in IDLE.
- Reset asserted mid-read releases the bus immediately (asynchronous).
- `rd_req` rises `SYNC_STAGES`+1 cycles after `vrd_n` falls at the pin.
- Data is driven the cycle after `rd_ack`.
- The bus is released `SYNC_STAGES`+1 cycles after `vrd_n` rises at the pin.
- `wr_valid` fires `SYNC_STAGES`+1 cycles after the write strobe rises at the pin.

## Configuration
- `VRAM_RESPONDER_STATS_EN`: when defined, adds outputs `rd_count` [15:0] and `wr_count` [15:0].
  - `rd_count` increments on entry to RD_WAIT; `wr_count` increments per `wr_valid`.
  - Both wrap at 0xFFFF→0 and reset to 0.
- When undefined, neither port exists and there is no counter logic.

## Structure
- `LVL_DIR_INPUT`/`LVL_DIR_OUTPUT` and the FSM state encodings live in the shared definitions include used by all bus blocks.
- Sub-module `vram_sync`: parameterized-width, `SYNC_STAGES`-deep synchronizer with falling/rising edge outputs, instantiated once for the whole bus bundle.

## Test plan
- Read, prompt ack: `vrd_n` low with `va14`=1, `vaa`=0x0123, `vab`=0x0456; client acks 2 cycles after `rd_req` with 0xA5/0x5A. Expect `rd_addr_a`=0x4123, `rd_addr_b`=0x4456, the bus driven with 0xA5/0x5A, and release within `SYNC_STAGES`+1 cycles of `vrd_n` rising.
- Late ack: `vrd_n` pulses for 3 cycles; ack is withheld for 10 cycles. Expect `rd_late`=1, the bus never driven, and `rd_req` held until ack and then dropped.
- Writes: A write 0x3C at `{0,0x1FFF}`, then B write 0xC3 at `{1,0x0000}`. Expect `wr_valid` pulses (sel 0, addr 0x1FFF, data 0x3C) then (sel 1, addr 0x4000, data 0xC3).
- Simultaneous A and B write rise: expect A on cycle n and B on cycle n+1, no event lost.
- `vrd_n` and `vawr_n` low together: expect `bus_err`=1, no `rd_req`, and the write still emitted.
- Reset during RD_DRIVE: expect `vda`/`vdb`=Z and `lvl_vd_dir`=`LVL_DIR_INPUT` without waiting for a clock edge. With `VRAM_RESPONDER_STATS_EN`, counters read 0 after reset and wrap after 65536 reads.
